obstacle_sched: RTL and testbench

OBSTACLE_SCHED -- requirements
Module: obstacle_sched

---
 rtl/juego_pkg.sv | 18 +
 rtl/obstacle_sched_if.sv | 19 +
 rtl/tick_div.sv | 26 ++
 rtl/obstacle_sched.sv | 123 ++++++++++++
 tb/tb_obstacle_sched.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/juego_pkg.sv
// Shared constants for the obstacle scheduler: game-state code, FSM encodings,
// field geometry and the spawn-pattern helper.
package juego_pkg;
  localparam logic [3:0] EN_JUEGO = 4'd3;
  localparam int         NCOLS    = 8;
  localparam int         CAMPO_W  = NCOLS * 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } estado_e;

  // All-lanes-blocked would be unwinnable, so lane 0 is always left open.
  function automatic logic [3:0] spawn_pat(input logic [3:0] aleo);
    return (aleo == 4'hF) ? 4'hE : aleo;
  endfunction
endpackage

// File: rtl/obstacle_sched_if.sv
// Game-side bus of the obstacle scheduler: control inputs and field/score outputs.
interface obstacle_sched_if;
  logic [3:0]  presente;
  logic [3:0]  obs_aleo;
  logic [1:0]  heroe_lane;
  logic [31:0] campo;
  logic        choque;
  logic [7:0]  puntos;
  logic [1:0]  estado;

  modport master (
    output presente, obs_aleo, heroe_lane,
    input  campo, choque, puntos, estado
  );
  modport slave (
    input  presente, obs_aleo, heroe_lane,
    output campo, choque, puntos, estado
  );
endinterface

// File: rtl/tick_div.sv
// Scroll-tick divider: counts 0..DIVIDER-1 while enabled, one-clk tick on the
// last count; held at zero while disabled. The tick is a clock enable.
module tick_div #(
  parameter int unsigned DIVIDER = 28'd71_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == W'(DIVIDER - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/obstacle_sched.sv
// Obstacle field scheduler: scrolls an 8x4 obstacle field toward the hero,
// scores ticks, detects collisions. OBSTACLE_SCHED_GAP_EN inserts an empty
// column after every spawned one.
module obstacle_sched
  import juego_pkg::*;
#(
  parameter int unsigned DIVIDER = 28'd71_000_000
) (
  input  logic             clk,
  input  logic             rst,
  obstacle_sched_if.slave  bus
);
  logic [3:0]         aleo_m_q, aleo_m_d, aleo_s_q, aleo_s_d;
  estado_e            state_q, state_d;
  logic [CAMPO_W-1:0] campo_q, campo_d;
  logic [7:0]         puntos_q, puntos_d;
  logic               choque_q, choque_d;
  logic [1:0]         estado_q, estado_d;
  logic [3:0]         col_new;
  logic               tick, hit, en_juego;
`ifdef OBSTACLE_SCHED_GAP_EN
  logic               gap_q, gap_d;
`endif

  tick_div #(.DIVIDER(DIVIDER)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  assign en_juego = (bus.presente == EN_JUEGO);
  // Column 0 is the hero column, so its low nibble is indexed by lane directly.
  assign hit      = campo_q[bus.heroe_lane];

`ifdef OBSTACLE_SCHED_GAP_EN
  assign col_new = gap_q ? 4'h0 : spawn_pat(aleo_s_q);
`else
  assign col_new = spawn_pat(aleo_s_q);
`endif

  always_comb begin
    aleo_m_d = bus.obs_aleo;
    aleo_s_d = aleo_m_q;
    state_d  = state_q;
    campo_d  = campo_q;
    puntos_d = puntos_q;
`ifdef OBSTACLE_SCHED_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        campo_d = '0;
        if (en_juego) begin
          state_d  = ST_RUN;
          puntos_d = '0;
`ifdef OBSTACLE_SCHED_GAP_EN
          gap_d    = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        // Leaving play outranks collision, which outranks the scroll tick.
        if (!en_juego) begin
          state_d = ST_IDLE;
          campo_d = '0;
        end else if (hit) begin
          state_d = ST_HIT;
        end else if (tick) begin
          campo_d  = {col_new, campo_q[CAMPO_W-1:4]};
          puntos_d = (puntos_q == 8'hFF) ? 8'hFF : puntos_q + 8'd1;
`ifdef OBSTACLE_SCHED_GAP_EN
          gap_d    = ~gap_q;
`endif
        end
      end
      ST_HIT: begin
        if (!en_juego) begin
          state_d = ST_IDLE;
          campo_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        campo_d = '0;
      end
    endcase
    choque_d = (state_d == ST_HIT);
    estado_d = state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aleo_m_q <= '0;
      aleo_s_q <= '0;
      state_q  <= ST_IDLE;
      campo_q  <= '0;
      puntos_q <= '0;
      choque_q <= 1'b0;
      estado_q <= '0;
    end else begin
      aleo_m_q <= aleo_m_d;
      aleo_s_q <= aleo_s_d;
      state_q  <= state_d;
      campo_q  <= campo_d;
      puntos_q <= puntos_d;
      choque_q <= choque_d;
      estado_q <= estado_d;
    end
  end

`ifdef OBSTACLE_SCHED_GAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gap_q <= 1'b0;
    else      gap_q <= gap_d;
  end
`endif

  assign bus.campo  = campo_q;
  assign bus.choque = choque_q;
  assign bus.puntos = puntos_q;
  assign bus.estado = estado_q;
endmodule

// File: tb/tb_obstacle_sched.sv
// Directed bench for obstacle_sched with DIVIDER=4: ticks land every 4th clk
// after entering RUN, so expected fields/scores are hand-derived per tick.
module tb_obstacle_sched;
  logic clk, rst;
  int   n_chk, n_pass;

  obstacle_sched_if bus_if();

  obstacle_sched #(.DIVIDER(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

`ifdef OBSTACLE_SCHED_GAP_EN
  localparam logic [31:0] F_E = 32'h0E0E0E0E;
  localparam logic [31:0] F_1 = 32'h01010101;
  localparam logic [31:0] F_4 = 32'h04040404;
`else
  localparam logic [31:0] F_E = 32'hEEEEEEEE;
  localparam logic [31:0] F_1 = 32'h11111111;
  localparam logic [31:0] F_4 = 32'h44444444;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_col;
    n_chk = 0; n_pass = 0;
    rst = 1'b0;
    bus_if.presente = 4'd0; bus_if.obs_aleo = 4'h0; bus_if.heroe_lane = 2'd0;
    #2;
    chk("rst_campo",  bus_if.campo,  32'h0);
    chk("rst_puntos", 32'(bus_if.puntos), 32'h0);
    chk("rst_choque", 32'(bus_if.choque), 32'h0);
    chk("rst_estado", 32'(bus_if.estado), 32'h0);
    #1 rst = 1'b1;
    step(2);
    chk("idle_hold", 32'(bus_if.estado), 32'd0);

    // First game: first tick four clks into RUN.
    bus_if.presente = 4'd3; bus_if.obs_aleo = 4'h1; bus_if.heroe_lane = 2'd3;
    step(1);
    chk("enter_run", 32'(bus_if.estado), 32'd1);
    step(3);
    chk("pre_tick_campo",  bus_if.campo, 32'h0);
    chk("pre_tick_puntos", 32'(bus_if.puntos), 32'd0);
    step(1);
    chk("tick1_campo",  bus_if.campo, 32'h1000_0000);
    chk("tick1_puntos", 32'(bus_if.puntos), 32'd1);

    // Leave play: field clears, score holds.
    bus_if.presente = 4'd0; bus_if.obs_aleo = 4'hF; bus_if.heroe_lane = 2'd0;
    step(1);
    chk("exit_estado", 32'(bus_if.estado), 32'd0);
    chk("exit_campo",  bus_if.campo, 32'h0);
    chk("exit_puntos", 32'(bus_if.puntos), 32'd1);

    // All-lanes pattern maps to 4'hE.
    bus_if.presente = 4'd3;
    step(1);
    chk("reenter_puntos", 32'(bus_if.puntos), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(4);
`ifdef OBSTACLE_SCHED_GAP_EN
      exp_col = (k % 2 == 1) ? 4'hE : 4'h0;
`else
      exp_col = 4'hE;
`endif
      chk($sformatf("spawn%0d", k), 32'(bus_if.campo[31:28]), 32'(exp_col));
    end
    chk("fieldE",    bus_if.campo, F_E);
    chk("fieldE_pts", 32'(bus_if.puntos), 32'd8);

    // Lane-0 obstacles walk down onto the hero.
    bus_if.obs_aleo = 4'h1;
    step(32);
    chk("pre_hit_campo",  bus_if.campo, F_1);
    chk("pre_hit_choque", 32'(bus_if.choque), 32'd0);
    chk("pre_hit_puntos", 32'(bus_if.puntos), 32'd16);
    step(1);
    chk("hit_choque", 32'(bus_if.choque), 32'd1);
    chk("hit_estado", 32'(bus_if.estado), 32'd2);
    step(20);
    chk("frz_campo",  bus_if.campo, F_1);
    chk("frz_puntos", 32'(bus_if.puntos), 32'd16);
    chk("frz_choque", 32'(bus_if.choque), 32'd1);

    // Exit from HIT, then re-entry clears the score.
    bus_if.presente = 4'd0; bus_if.obs_aleo = 4'h4;
    step(1);
    chk("hitexit_estado", 32'(bus_if.estado), 32'd0);
    chk("hitexit_campo",  bus_if.campo, 32'h0);
    chk("hitexit_puntos", 32'(bus_if.puntos), 32'd16);
    bus_if.presente = 4'd3; bus_if.heroe_lane = 2'd1;
    step(1);
    chk("reenter2_puntos", 32'(bus_if.puntos), 32'd0);
    chk("reenter2_estado", 32'(bus_if.estado), 32'd1);

    // Hero steps into lane 2 on the same clk a tick is due: collision wins.
    step(32);
    chk("lane2_campo",  bus_if.campo, F_4);
    chk("lane2_puntos", 32'(bus_if.puntos), 32'd8);
    step(3);
    bus_if.heroe_lane = 2'd2;
    step(1);
    chk("move_hit_estado", 32'(bus_if.estado), 32'd2);
    chk("move_hit_choque", 32'(bus_if.choque), 32'd1);
    chk("move_hit_campo",  bus_if.campo, F_4);
    chk("move_hit_puntos", 32'(bus_if.puntos), 32'd8);
    step(4);
    chk("move_frz_campo",  bus_if.campo, F_4);
    chk("move_frz_puntos", 32'(bus_if.puntos), 32'd8);

    // Score saturation.
    bus_if.presente = 4'd0;
    step(1);
    bus_if.presente = 4'd3; bus_if.heroe_lane = 2'd1;
    step(1);
    step(4 * 254);
    chk("pts_254", 32'(bus_if.puntos), 32'hFE);
    step(4);
    chk("pts_255", 32'(bus_if.puntos), 32'hFF);
    step(4);
    chk("pts_sat", 32'(bus_if.puntos), 32'hFF);
    chk("sat_estado", 32'(bus_if.estado), 32'd1);

    // Asynchronous reset mid-RUN.
    #2 rst = 1'b0;
    #1;
    chk("arst_campo",  bus_if.campo, 32'h0);
    chk("arst_puntos", 32'(bus_if.puntos), 32'h0);
    chk("arst_choque", 32'(bus_if.choque), 32'h0);
    chk("arst_estado", 32'(bus_if.estado), 32'h0);
    bus_if.presente = 4'd0;
    #3 rst = 1'b1;
    step(3);
    chk("post_rst_idle", 32'(bus_if.estado), 32'd0);
    chk("post_rst_campo", bus_if.campo, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
